spectrum_bar_writer: RTL
========================

Name: spectrum_bar_writer

Overview:
- Pixel-write source for the VRAM controller's write port. It drives Screen, X, Y and Color, paced by SWClockEn and started by StartLoader.
- Per frame it reads one spectrum magnitude per column from the magnitude RAM, for both L and R channels.
- It renders each column as a vertical bar with a green/yellow/red zone gradient.
- It sits between the FFT magnitude RAM and the VRAM controller, clocked by the 64 MHz system clock.

Parameters:
- H_PIXELS, 320, columns per screen; one bin per column.
- V_PIXELS, 128, rows per screen.
- BW_MAG, 16, magnitude input width.
- MAG_SHIFT, 8, right shift applied to the magnitude to get bar height in rows.
- ZONE_MID, 64, first row index (counted from the bottom) drawn yellow.
- ZONE_HI, 104, first row index (counted from the bottom) drawn red.

Ports:
- Clock  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- StartLoader  in  1  one-cycle frame-start pulse from the VRAM controller.
- SWClockEn  in  1  write slot from the VRAM controller. A pixel is consumed on a cycle where SWClockEn=1 and WrEn=1.
- BinAddr  out  9  magnitude RAM read address (column index).
- BinMagL  in  BW_MAG  L magnitude; valid 1 cycle after BinAddr.
- BinMagR  in  BW_MAG  R magnitude; valid 1 cycle after BinAddr.
- WrEn  out  1  Screen/X/Y/Color hold a valid pixel.
- Screen  out  1  0 = L LCD, 1 = R LCD.
- X  out  9  pixel column.
- Y  out  7  pixel row; 0 = top.
- Color  out  15  RGB555 pixel, R in bits [14:10].
- Busy  out  1  high from frame start until Done.
- Done  out  1  one-cycle pulse after the last pixel is consumed.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- State IDLE:
  - StartLoader=1 -> ADDR, with Screen=0, X=0, Busy=1.
  - Otherwise stay in IDLE.
- State ADDR: BinAddr=X for exactly 1 cycle -> LATCH. WrEn=0.
- State LATCH:
  - Select BinMagL if Screen=0, else BinMagR.
  - height = mag >> MAG_SHIFT, saturated to V_PIXELS (unsigned).
  - Set Y=0 -> EMIT. WrEn=0.
- State EMIT: WrEn=1.
  - Row index r = V_PIXELS-1-Y, so r=0 is the bottom row.
  - Lit if r < height. Lit colour: 15'h7C00 if r>=ZONE_HI, else 15'h7FE0 if r>=ZONE_MID, else 15'h03E0.
  - Unlit colour: 15'h0000.
  - Color is combinational or registered, but must match the current Y whenever WrEn=1.
  - On a consumed cycle:
    - If Y<V_PIXELS-1: Y++.
    - Else if X<H_PIXELS-1: X++ -> ADDR.
    - Else if Screen=0: Screen=1, X=0 -> ADDR.
    - Else -> DONE.
  - SWClockEn=0 holds all outputs stable. The stall length is unbounded.
- State DONE: Done=1 and Busy=0 for 1 cycle -> IDLE. WrEn=0.
- Column cost: 2 non-writing cycles plus V_PIXELS consumed cycles.
- Frame size: 2*H_PIXELS*V_PIXELS consumed writes, in order L then R, column-major, top to bottom.
- StartLoader while Busy=1 or in DONE: ignored; no restart or queuing.
- height=0: the whole column is unlit. height>=V_PIXELS: the whole column is lit.
- WrEn is never high outside EMIT. No pixel is emitted twice or skipped.
- Reset asserted mid-frame: immediate return to the reset values. The partial frame is abandoned, with no Done pulse.

Test Plan:
- Reset release, no StartLoader for 100 cycles -> all outputs 0, WrEn never high.
- StartLoader, BinMagL[0]=16'h1234, SWClockEn=1 constantly.
  - Column 0 L: height 18; Y=0..109 Color=0, Y=110..127 Color=15'h03E0.
  - BinAddr=0 one cycle before the first WrEn.
- BinMagR[5]=16'hFFFF -> Screen=1, X=5 column fully lit:
  - Y=0..23 Color=15'h7C00.
  - Y=24..63 Color=15'h7FE0.
  - Y=64..127 Color=15'h03E0.
- SWClockEn toggling at random 30% duty -> consumed pixel sequence identical to the continuous run.
  - Outputs stable during SWClockEn=0.
  - Exactly 81920 consumed writes, then a single Done pulse.
- StartLoader re-pulsed at X=100 -> ignored; frame continues to completion. StartLoader 1 cycle after Done -> new frame starts at Screen=0, X=0.
- Reset asserted at Screen=1, X=200, Y=50 -> next cycle all outputs 0, no Done. A following StartLoader produces a full correct frame.

Source files
------------

// File: rtl/spectrum_bar_writer.sv
// rtl/spectrum_bar_writer.sv - renders L/R spectrum magnitudes as zoned vertical bars into VRAM
module spectrum_bar_writer #(
   parameter int H_PIXELS  = 320,
   parameter int V_PIXELS  = 128,
   parameter int BW_MAG    = 16,
   parameter int MAG_SHIFT = 8,
   parameter int ZONE_MID  = 64,
   parameter int ZONE_HI   = 104
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              StartLoader,
   input  logic              SWClockEn,
   output logic [8:0]        BinAddr,
   input  logic [BW_MAG-1:0] BinMagL,
   input  logic [BW_MAG-1:0] BinMagR,
   output logic              WrEn,
   output logic              Screen,
   output logic [8:0]        X,
   output logic [6:0]        Y,
   output logic [14:0]       Color,
   output logic              Busy,
   output logic              Done
);

   // Height must be able to hold V_PIXELS itself (a fully lit column).
   localparam int         HW     = $clog2(V_PIXELS + 1);
   localparam logic [8:0] X_LAST = 9'(H_PIXELS - 1);
   localparam logic [6:0] Y_LAST = 7'(V_PIXELS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_LATCH,
      S_EMIT,
      S_DONE
   } state_t;

   state_t          state, state_nx;
   logic            screen_q, screen_nx;
   logic [8:0]      x_q, x_nx;
   logic [6:0]      y_q, y_nx;
   logic [HW-1:0]   height_q, height_nx;
   logic [BW_MAG-1:0] mag_sel;
   logic [BW_MAG-1:0] mag_rows;
   logic [6:0]      row;

   // State and pixel-position registers.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state    <= S_IDLE;
         screen_q <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         height_q <= '0;
      end else begin
         state    <= state_nx;
         screen_q <= screen_nx;
         x_q      <= x_nx;
         y_q      <= y_nx;
         height_q <= height_nx;
      end
   end

   // Next-state logic: column walk L then R, top to bottom, advancing only on consumed slots.
   always_comb begin
      state_nx  = state;
      screen_nx = screen_q;
      x_nx      = x_q;
      y_nx      = y_q;
      height_nx = height_q;
      mag_sel   = screen_q ? BinMagR : BinMagL;
      mag_rows  = mag_sel >> MAG_SHIFT;
      case (state)
         S_IDLE: begin
            if (StartLoader) begin
               state_nx  = S_ADDR;
               screen_nx = 1'b0;
               x_nx      = '0;
            end
         end
         S_ADDR: state_nx = S_LATCH;
         S_LATCH: begin
            height_nx = (mag_rows >= BW_MAG'(V_PIXELS)) ? HW'(V_PIXELS) : HW'(mag_rows);
            y_nx      = '0;
            state_nx  = S_EMIT;
         end
         S_EMIT: begin
            if (SWClockEn) begin
               if (y_q < Y_LAST) begin
                  y_nx = y_q + 7'd1;
               end else if (x_q < X_LAST) begin
                  x_nx     = x_q + 9'd1;
                  state_nx = S_ADDR;
               end else if (!screen_q) begin
                  screen_nx = 1'b1;
                  x_nx      = '0;
                  state_nx  = S_ADDR;
               end else begin
                  state_nx = S_DONE;
               end
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Pixel colour for the current row; row 0 is the bottom of the bar.
   always_comb begin
      Color = 15'h0000;
      row   = Y_LAST - y_q;
      if (state == S_EMIT && HW'(row) < height_q) begin
         if (row >= 7'(ZONE_HI))
            Color = 15'h7C00;
         else if (row >= 7'(ZONE_MID))
            Color = 15'h7FE0;
         else
            Color = 15'h03E0;
      end
   end

   // RAM address follows the column so the magnitude is ready by LATCH.
   assign BinAddr = x_q;
   assign WrEn    = (state == S_EMIT);
   assign Screen  = screen_q;
   assign X       = x_q;
   assign Y       = y_q;
   assign Busy    = (state == S_ADDR) || (state == S_LATCH) || (state == S_EMIT);
   assign Done    = (state == S_DONE);

endmodule
